// File: rtl/seq_div_core.sv
// Multi-cycle radix-2 restoring unsigned divider: one quotient bit per clock.
// Optional divide-by-zero fast path and dbz flag under `SEQ_DIV_CORE_DBZ_EN.
module seq_div_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             DivResult,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_CORE_DBZ_EN
  ,
  output logic             dbz
`endif
);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  // Partial remainder never reaches the divisor, so WIDTH bits hold it; the
  // shifted value needs one extra bit and the trial subtraction's MSB is its sign.
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;

  assign r_sh  = {r_q, q_q[WIDTH-1]};
  assign trial = r_sh - {1'b0, d_q};

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef SEQ_DIV_CORE_DBZ_EN
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_BUSY: begin
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        r_d   = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = busy_q;
  assign DivResult = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
`ifdef SEQ_DIV_CORE_DBZ_EN
  assign dbz       = dbz_q;
`else
  logic unused_dbz;
  assign unused_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_seq_div_core.sv
// Self-checking bench for seq_div_core: directed timing sequences, a vector
// table and a random sweep, all checked through an expected-result queue.
module tb_seq_div_core;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 5;
`ifdef SEQ_DIV_CORE_DBZ_EN
  localparam int DBZ_LAT = 1;
  localparam bit DBZ_ON  = 1'b1;
`else
  localparam int DBZ_LAT = 9;
  localparam bit DBZ_ON  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             DivResult;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef SEQ_DIV_CORE_DBZ_EN
  logic             dbz;
`endif

  always #5 clk = ~clk;

  seq_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .DivResult (DivResult),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIV_CORE_DBZ_EN
    ,
    .dbz       (dbz)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
  } vec_t;

  vec_t vecs[8];
  logic [2*WIDTH:0] sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned n_done = 0;
  int unsigned n_issued = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one start strobe for the current cycle and records the expected result.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
    logic edbz;
    edbz = DBZ_ON && (b == '0);
    i_valid  = 1'b1;
    dividend = a;
    divisor  = b;
    sb_q.push_back({edbz, eq, er});
    n_issued++;
    next_cycle();
    i_valid  = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  // Counts cycles after the issue cycle until DivResult; -1 if the budget expires.
  task automatic measure(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (DivResult === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: no DivResult within 20 cycles at %0t", $time);
    end
  endtask

  // Scoreboard: every completion pulse pops and compares one expected result.
  always @(negedge clk) begin
    logic [2*WIDTH:0] e;
    if (DivResult === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got DivResult=1 expected no pulse at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("quotient", 32'(quotient), 32'(e[2*WIDTH-1:WIDTH]));
        check("remainder", 32'(remainder), 32'(e[WIDTH-1:0]));
`ifdef SEQ_DIV_CORE_DBZ_EN
        check("dbz", 32'(dbz), 32'(e[2*WIDTH]));
`endif
      end
    end
`ifdef SEQ_DIV_CORE_DBZ_EN
    else if (dbz !== 1'b0) begin
      check("dbz_idle", 32'(dbz), 32'd0);
    end
`endif
  end

  initial begin
    int lat;
    logic [WIDTH-1:0] a, b;

    vecs[0] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    vecs[1] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5};
    vecs[2] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100};
    vecs[3] = '{a: 8'd50,  b: 8'd6,   q: 8'd8,   r: 8'd2};
    vecs[4] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0};
    vecs[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};
    vecs[6] = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254};
    vecs[7] = '{a: 8'd128, b: 8'd3,   q: 8'd42,  r: 8'd2};

    reset = 1'b1; i_valid = 1'b0; dividend = '0; divisor = '0;
    repeat (3) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(DivResult), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);

    // 200/7: pulse only in C0+9, busy across C0+1..C0+9
    next_cycle();
    issue(8'd200, 8'd7, 8'd28, 8'd4);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      check($sformatf("t1_busy_c%0d", n), 32'(busy), (n <= 9) ? 32'd1 : 32'd0);
      check($sformatf("t1_done_c%0d", n), 32'(DivResult), (n == 9) ? 32'd1 : 32'd0);
    end

    // 255/1 then 5/9: first result held until the second completes
    next_cycle();
    issue(8'd255, 8'd1, 8'd255, 8'd0);
    measure(lat);
    next_cycle();
    issue(8'd5, 8'd9, 8'd0, 8'd5);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check("hold_quot", 32'(quotient), 32'd255);
      check("hold_rem", 32'(remainder), 32'd0);
    end
    measure(lat);
    check("hold_lat", 32'(lat), 32'd1);

    // Divide by zero latency
    next_cycle();
    issue(8'd100, 8'd0, 8'd255, 8'd100);
    measure(lat);
    check("dbz_lat", 32'(lat), 32'(DBZ_LAT));
    repeat (10) next_cycle();

    // Start strobes during BUSY/DONE are ignored
    issue(8'd200, 8'd7, 8'd28, 8'd4);
    for (int n = 1; n <= 9; n++) begin
      i_valid  = 1'b1;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom_range(1, 255));
      @(negedge clk);
      check($sformatf("ign_busy_c%0d", n), 32'(busy), 32'd1);
      check($sformatf("ign_done_c%0d", n), 32'(DivResult), (n == 9) ? 32'd1 : 32'd0);
      next_cycle();
    end
    i_valid = 1'b0;
    @(negedge clk);
    check("ign_idle_busy", 32'(busy), 32'd0);

    // Reset mid-operation abandons the result
    next_cycle();
    issue(8'd200, 8'd7, 8'd28, 8'd4);
    repeat (3) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sb_q.delete();
    n_issued--;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(DivResult), 32'd0);
    check("mid_rst_quot", 32'(quotient), 32'd0);
    check("mid_rst_rem", 32'(remainder), 32'd0);
    next_cycle();
    issue(8'd50, 8'd6, 8'd8, 8'd2);
    measure(lat);
    check("post_rst_lat", 32'(lat), 32'd9);

    // Vector table, issued back-to-back
    foreach (vecs[i]) begin
      next_cycle();
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      measure(lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), (vecs[i].b == '0) ? 32'(DBZ_LAT) : 32'd9);
    end

    // Random sweep against / and %
    for (int i = 0; i < 2000; i++) begin
      a = WIDTH'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : WIDTH'($urandom);
      next_cycle();
      if (b == '0) issue(a, b, '1, a);
      else         issue(a, b, a / b, a % b);
      measure(lat);
    end

    repeat (12) next_cycle();
    check("done_count", 32'(n_done), 32'(n_issued));
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
